// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// Produces {remainder, quotient} after WIDTH iterations and holds it while EX is frozen.
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_req,
  input  logic                 div_signed,
  input  logic [WIDTH-1:0]     div_opdata1,
  input  logic [WIDTH-1:0]     div_opdata2,
  input  logic                 annul,
  input  logic                 hold,
  output logic                 stallreq_for_div,
  output logic                 div_ready,
  output logic [2*WIDTH-1:0]   div_result,
  output logic                 busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StDivZero, StOn, StEnd} state_e;

  state_e             r_state, w_state_next;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH:0]   r_part;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_neg_q, r_neg_r;
  logic               r_ready;
  logic [2*WIDTH-1:0] r_result;

  logic [2*WIDTH:0]   w_shift, w_step;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quot, w_rem, w_q_raw, w_r_raw;
  logic               w_last;

  assign w_abs_a = (div_signed && div_opdata1[WIDTH-1]) ? -div_opdata1 : div_opdata1;
  assign w_abs_b = (div_signed && div_opdata2[WIDTH-1]) ? -div_opdata2 : div_opdata2;
  assign w_last  = (r_cnt == CntW'(WIDTH - 1));

  // One restoring step: shift, trial-subtract from the upper half, keep if non-negative.
  always_comb begin
    w_shift = r_part << 1;
    w_diff  = w_shift[2*WIDTH:WIDTH] - {1'b0, r_divisor};
    w_step  = w_shift;
    if (!w_diff[WIDTH]) begin
      w_step[2*WIDTH:WIDTH] = w_diff;
      w_step[0]             = 1'b1;
    end
    w_q_raw = w_step[WIDTH-1:0];
    w_r_raw = w_step[2*WIDTH-1:WIDTH];
    w_quot  = r_neg_q ? -w_q_raw : w_q_raw;
    w_rem   = r_neg_r ? -w_r_raw : w_r_raw;
  end

  always_comb begin
    w_state_next = r_state;
    if (annul) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (div_req) begin
            w_state_next = (div_opdata2 == '0) ? StDivZero : StOn;
          end
        end
        StDivZero: w_state_next = StEnd;
        StOn:      if (w_last) w_state_next = StEnd;
        StEnd:     if (!hold) w_state_next = StIdle;
        default:   w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_part    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_next;
      if (annul) begin
        r_cnt   <= '0;
        r_ready <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_cnt <= '0;
            if (div_req && (div_opdata2 != '0)) begin
              r_part    <= {{(WIDTH + 1){1'b0}}, w_abs_a};
              r_divisor <= w_abs_b;
              r_neg_q   <= div_signed & (div_opdata1[WIDTH-1] ^ div_opdata2[WIDTH-1]);
              r_neg_r   <= div_signed & div_opdata1[WIDTH-1];
            end
          end
          StDivZero: begin
            r_result <= '0;
            r_ready  <= 1'b1;
          end
          StOn: begin
            r_part <= w_step;
            r_cnt  <= r_cnt + CntW'(1);
            if (w_last) begin
              r_result <= {w_rem, w_quot};
              r_ready  <= 1'b1;
            end
          end
          StEnd: begin
            if (!hold) r_ready <= 1'b0;
          end
          default: r_ready <= 1'b0;
        endcase
      end
    end
  end

  assign div_ready        = r_ready;
  assign div_result       = r_result;
  assign busy             = (r_state != StIdle);
  assign stallreq_for_div = div_req & ~r_ready & ~annul;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed table, annul/reset/hold sequences, random ops.
module tb_div_ctrl;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst, div_req, div_signed, annul, hold;
  logic [W-1:0]   div_opdata1, div_opdata2;
  logic           stallreq_for_div, div_ready, busy;
  logic [2*W-1:0] div_result;

  div_ctrl #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .div_req          (div_req),
    .div_signed       (div_signed),
    .div_opdata1      (div_opdata1),
    .div_opdata2      (div_opdata2),
    .annul            (annul),
    .hold             (hold),
    .stallreq_for_div (stallreq_for_div),
    .div_ready        (div_ready),
    .div_result       (div_result),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [31:0] q;
    logic [31:0] r;
    int          hold_n;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: divide magnitudes with plain arithmetic, then fix signs modulo 2^32.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input bit s);
    longint unsigned mx, my, q, r;
    bit nx, ny;
    if (y == 0) return 64'd0;
    nx = s && x[31];
    ny = s && y[31];
    mx = nx ? (64'h1_0000_0000 - longint'(x)) : longint'(x);
    my = ny ? (64'h1_0000_0000 - longint'(y)) : longint'(y);
    q  = mx / my;
    r  = mx % my;
    if (nx ^ ny) q = 64'h1_0000_0000 - q;
    if (nx) r = 64'h1_0000_0000 - r;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one divide, check stall window, latency, result, optional hold in END, and exit.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit s,
                        input logic [63:0] exp, input int hold_n, input string tag);
    int k;
    int lat_exp;
    bit st_ok;
    logic [63:0] res;
    lat_exp = (y == 0) ? 2 : W + 1;
    @(negedge clk);
    div_req = 1'b1; div_opdata1 = x; div_opdata2 = y; div_signed = s;
    #1;
    k = 0;
    st_ok = 1'b1;
    while (!div_ready && k < 200) begin
      if (stallreq_for_div !== 1'b1) st_ok = 1'b0;
      @(negedge clk);
      if (k >= 1) begin
        div_opdata1 = $urandom;
        div_opdata2 = $urandom;
      end
      #1;
      k++;
    end
    chk({tag, " stall"}, 64'(st_ok), 64'd1);
    chk({tag, " latency"}, 64'(k), 64'(lat_exp));
    chk({tag, " result"}, div_result, exp);
    chk({tag, " stall_end"}, 64'(stallreq_for_div), 64'd0);
    res = div_result;
    if (hold_n > 0) begin
      hold = 1'b1;
      repeat (hold_n - 1) begin
        @(negedge clk); #1;
        chk({tag, " hold_ready"}, 64'(div_ready), 64'd1);
        chk({tag, " hold_result"}, div_result, res);
      end
      @(negedge clk);
      hold = 1'b0;
      #1;
      chk({tag, " hold_last"}, 64'(div_ready), 64'd1);
    end
    div_req = 1'b0;
    @(negedge clk); #1;
    chk({tag, " exit_ready"}, 64'(div_ready), 64'd0);
    chk({tag, " exit_busy"}, 64'(busy), 64'd0);
    chk({tag, " exit_result"}, div_result, res);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [63:0] prev;
    bit s;
    int sel;

    tbl[0] = '{32'd100,       32'd7,          1'b0, 32'h0000000E, 32'h00000002, 0};
    tbl[1] = '{32'hFFFFFFF9,  32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 0};
    tbl[2] = '{32'd7,         32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'h00000001, 0};
    tbl[3] = '{32'd5,         32'd0,          1'b0, 32'h00000000, 32'h00000000, 0};
    tbl[4] = '{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000, 32'h00000000, 0};
    tbl[5] = '{32'hFFFFFFFF,  32'd1,          1'b0, 32'hFFFFFFFF, 32'h00000000, 5};
    tbl[6] = '{32'hFFFFFFF9,  32'd2,          1'b0, 32'h7FFFFFFC, 32'h00000001, 0};

    rst = 1'b1; div_req = 1'b0; div_signed = 1'b0; annul = 1'b0; hold = 1'b0;
    div_opdata1 = '0; div_opdata2 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready", 64'(div_ready), 64'd0);
    chk("reset result", div_result, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset stall", 64'(stallreq_for_div), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, {tbl[i].r, tbl[i].q}, tbl[i].hold_n,
             $sformatf("tbl%0d", i));
    end

    // Annul mid-operation, then a fresh DIVU 9/3 starting two cycles later.
    prev = div_result;
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; div_opdata1 = 32'd100; div_opdata2 = 32'd7;
    repeat (9) @(negedge clk);
    @(negedge clk);
    annul = 1'b1;
    #1;
    chk("annul stall", 64'(stallreq_for_div), 64'd0);
    chk("annul busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    annul = 1'b0; div_req = 1'b0;
    #1;
    chk("annul busy", 64'(busy), 64'd0);
    chk("annul ready", 64'(div_ready), 64'd0);
    chk("annul result", div_result, prev);
    run_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 0, "post_annul");

    // Reset mid-operation clears everything; next op completes normally.
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b1; div_opdata1 = 32'd1000; div_opdata2 = 32'd3;
    repeat (4) @(negedge clk);
    @(negedge clk);
    rst = 1'b1; div_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst ready", 64'(div_ready), 64'd0);
    chk("rst result", div_result, 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst stall", 64'(stallreq_for_div), 64'd0);
    run_op(32'd1000, 32'hFFFFFFFD, 1'b1, ref_div(32'd1000, 32'hFFFFFFFD, 1'b1), 0, "post_rst");

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 7);
      x = $urandom;
      y = $urandom;
      s = 1'($urandom_range(0, 1));
      if (sel == 0) y = 32'd0;
      else if (sel == 1) y = 32'($urandom_range(1, 15));
      else if (sel == 2) y = 32'hFFFFFFFF;
      if ($urandom_range(0, 5) == 0) x = 32'h80000000;
      run_op(x, y, s, ref_div(x, y, s), (sel == 3) ? 2 : 0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
